// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel-bus capture: synchronises PCLK/VSYNC/HREF/D into CLK,
// pairs bytes into RGB565, tracks raw X/Y, crops the centred window and
// presents pixels on a valid/ready handshake, counting drops.
// Ports: CLK, RST (sync, active-high); i_enable, i_pclk, i_vsync, i_href,
// i_data[7:0], i_ready in; o_pixel[15:0], o_valid, o_x[9:0], o_y[8:0],
// o_frame_start, o_frame_done, o_drop_count[15:0], o_busy out.
module ov7670_pixel_capture #(
    parameter int unsigned FrameWidth        = 640,
    parameter int unsigned FrameHeight       = 480,
    parameter int unsigned ActiveFrameWidth  = 512,
    parameter int unsigned ActiveFrameHeight = 384,
    parameter int unsigned CropX             = 64,
    parameter int unsigned CropY             = 48
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_enable,
    input  logic        i_pclk,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic [7:0]  i_data,
    input  logic        i_ready,
    output logic [15:0] o_pixel,
    output logic        o_valid,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_frame_start,
    output logic        o_frame_done,
    output logic [15:0] o_drop_count,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_e;

    localparam logic [9:0] XMax = 10'(FrameWidth);
    localparam logic [9:0] XLo  = 10'(CropX);
    localparam logic [9:0] XHi  = 10'(CropX + ActiveFrameWidth);
    localparam logic [8:0] YMax = 9'(FrameHeight);
    localparam logic [8:0] YLo  = 9'(CropY);
    localparam logic [8:0] YHi  = 9'(CropY + ActiveFrameHeight);

    // [0],[1] are the synchroniser pair, [2] is the edge-detect history
    logic [2:0]  pclk_q, vsync_q, href_q;
    logic [7:0]  data_s1_q, data_s2_q;

    // Registered edge events, aligned with the byte they qualify
    logic        pclk_rise_q, href_fall_q, vs_rise_q, vs_fall_q, href_lvl_q;
    logic [7:0]  byte_q;

    state_e      state_q, state_d;
    logic        seen_q, seen_d;
    logic        start_d, done_d, start_q, done_q;

    logic [9:0]  xr_q, xr_d;
    logic [8:0]  yr_q, yr_d;
    logic        ph_q, ph_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] pix_q, pix_d;
    logic [9:0]  px_q, px_d;
    logic [8:0]  py_q, py_d;
    logic        stb_q, stb_d;
    logic        in_win;

    logic        valid_q, valid_d;
    logic [15:0] opix_q, opix_d;
    logic [9:0]  ox_q, ox_d;
    logic [8:0]  oy_q, oy_d;
    logic [15:0] drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                seen_d = 1'b0;
                if (i_enable) state_d = SYNC;
            end
            SYNC: begin
                // A falling edge only counts once VSYNC was seen high here
                if (vsync_q[2]) seen_d = 1'b1;
                if (vs_fall_q && seen_q) begin
                    state_d = CAPTURE;
                    start_d = 1'b1;
                    seen_d  = 1'b0;
                end
            end
            CAPTURE: begin
                if (vs_rise_q) begin
                    done_d  = 1'b1;
                    state_d = i_enable ? SYNC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_win = (xr_q >= XLo) && (xr_q < XHi) &&
                    (yr_q >= YLo) && (yr_q < YHi);

    always_comb begin
        xr_d  = xr_q;
        yr_d  = yr_q;
        ph_d  = ph_q;
        hi_d  = hi_q;
        pix_d = pix_q;
        px_d  = px_q;
        py_d  = py_q;
        stb_d = 1'b0;
        if (start_d) begin
            xr_d = '0;
            yr_d = '0;
            ph_d = 1'b0;
        end else if (state_q == CAPTURE) begin
            if (href_fall_q) begin
                xr_d = '0;
                ph_d = 1'b0;
                if (yr_q != YMax) yr_d = yr_q + 9'd1;
            end else if (pclk_rise_q && href_lvl_q) begin
                if (!ph_q) begin
                    hi_d = byte_q;
                    ph_d = 1'b1;
                end else begin
                    ph_d  = 1'b0;
                    pix_d = {hi_q, byte_q};
                    px_d  = xr_q - XLo;
                    py_d  = yr_q - YLo;
                    stb_d = in_win;
                    // Saturate so overlong lines never wrap into the window
                    if (xr_q != XMax) xr_d = xr_q + 10'd1;
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        opix_d  = opix_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        drop_d  = drop_q;
        if (stb_q) begin
            if (!valid_q || i_ready) begin
                valid_d = 1'b1;
                opix_d  = pix_q;
                ox_d    = px_q;
                oy_d    = py_q;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pclk_q      <= '0;
            vsync_q     <= '0;
            href_q      <= '0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
            pclk_rise_q <= 1'b0;
            href_fall_q <= 1'b0;
            vs_rise_q   <= 1'b0;
            vs_fall_q   <= 1'b0;
            href_lvl_q  <= 1'b0;
            byte_q      <= '0;
            state_q     <= IDLE;
            seen_q      <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            xr_q        <= '0;
            yr_q        <= '0;
            ph_q        <= 1'b0;
            hi_q        <= '0;
            pix_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            stb_q       <= 1'b0;
            valid_q     <= 1'b0;
            opix_q      <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            drop_q      <= '0;
        end else begin
            pclk_q      <= {pclk_q[1:0], i_pclk};
            vsync_q     <= {vsync_q[1:0], i_vsync};
            href_q      <= {href_q[1:0], i_href};
            data_s1_q   <= i_data;
            data_s2_q   <= data_s1_q;
            pclk_rise_q <= pclk_q[1] & ~pclk_q[2];
            href_fall_q <= ~href_q[1] & href_q[2];
            vs_rise_q   <= vsync_q[1] & ~vsync_q[2];
            vs_fall_q   <= ~vsync_q[1] & vsync_q[2];
            href_lvl_q  <= href_q[1];
            byte_q      <= data_s2_q;
            state_q     <= state_d;
            seen_q      <= seen_d;
            start_q     <= start_d;
            done_q      <= done_d;
            xr_q        <= xr_d;
            yr_q        <= yr_d;
            ph_q        <= ph_d;
            hi_q        <= hi_d;
            pix_q       <= pix_d;
            px_q        <= px_d;
            py_q        <= py_d;
            stb_q       <= stb_d;
            valid_q     <= valid_d;
            opix_q      <= opix_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            drop_q      <= drop_d;
        end
    end

    assign o_pixel       = opix_q;
    assign o_valid       = valid_q;
    assign o_x           = ox_q;
    assign o_y           = oy_q;
    assign o_frame_start = start_q;
    assign o_frame_done  = done_q;
    assign o_drop_count  = drop_q;
    assign o_busy        = (state_q == CAPTURE);

endmodule
